benes_network: RTL
==================

# benes_network

Pipelined, parametrised permutation network for the matrix-transpose datapath. It generalises the fixed butterfly network in three ways:
- selectable full Benes topology (2·log2N−1 stages, rearrangeable), alongside plain butterfly;
- configurable register placement;
- valid/ready backpressure with an in-flight counter.

It sits between the transpose buffer read port and the downstream consumer. It routes one N-element beat per cycle under per-beat switch control.

## Interface
- DATA_WIDTH, 64, element width
- NUM_INPUTS, 16, lane count N; power of 2, ≥ 2
- BENES, 1, 1 = Benes topology (2L−1 stages), 0 = butterfly (L stages); L = log2(N)
- REG_EVERY, 1, pipeline register after every REG_EVERY stages; the last stage is always registered
- derived: NUM_STAGES, NUM_SWITCHES = N/2, NUM_REGS = ceil(NUM_STAGES/REG_EVERY), CNT_W = $clog2(NUM_REGS+1)

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- in_val  input  1  input beat valid
- in_rdy  output  1  network accepts a beat this cycle
- input_elements  input  DATA_WIDTH × N  unpacked lanes [0:N−1]
- ctrl_arr  input  NUM_SWITCHES × NUM_STAGES  per-stage switch controls, sampled with the beat
- out_val  output  1  output beat valid
- out_rdy  input  1  consumer accepts the output beat
- output_elements  output  DATA_WIDTH × N  permuted lanes
- in_flight  output  CNT_W  number of valid pipeline registers

## Operation
- Stage s has pair distance d(s):
  - s < L: d(s) = 2^(L−1−s)
  - s ≥ L: d(s) = 2^(s−L+1), Benes only
  - Example, N=16 Benes: 8, 4, 2, 1, 2, 4, 8.
- Switch k of a stage joins lane a = (k / d)·2d + (k mod d) with lane a+d.
  - ctrl bit k = 0: pass.
  - ctrl bit k = 1: swap (out[a] = in[a+d], out[a+d] = in[a]).
- Control bits travel with their beat. Controls for stages after a register are carried in that register alongside the data, so each beat uses exactly the controls presented at its acceptance.
- Each register slot r holds v[r], data and remaining controls.
  - Load condition: ready_r = !v[r] || ready_(r+1), with ready_NUM_REGS = out_rdy.
  - in_rdy = ready_0; out_val = v[NUM_REGS−1]; output_elements is the last data register.
- Beats never reorder, drop or duplicate. Data transfers only on val && rdy.
- in_flight: +1 on input handshake, −1 on output handshake, unchanged if both happen in the same cycle. Range 0..NUM_REGS.

## Timing
- Reset (rst low, asynchronous): all v[r] = 0, data/control registers = 0, out_val = 0, output_elements = 0, in_flight = 0. in_rdy is 1 from the first cycle after reset deasserts.
- Latency: NUM_REGS cycles from input handshake to out_val with no stall. Throughput: 1 beat/cycle with out_rdy held high.
- in_rdy depends combinationally on out_rdy through the ready chain. No output depends combinationally on in_val or input_elements.
- Full: all v set and out_rdy = 0 → in_rdy = 0, in_flight = NUM_REGS, outputs hold stable.
- Simultaneous output and input handshake while full: accepted; in_flight unchanged.
- Reset mid-operation: in-flight beats are discarded, never emitted.
- Input values while in_val = 0 are ignored.

## Structure
- Shared package benes_pkg:
  - function stage_distance(s, L, benes)
  - function switch_lane(k, d)
  - CNT_W helper
- Sub-module benes_stage: combinational single stage parametrised by DATA_WIDTH, NUM_INPUTS, DIST, with ctrl input.
- benes_network generates the stage chain, register slots, ready chain and in_flight counter.

## Test plan
All scenarios use N=4, BENES=1, REG_EVERY=1, so NUM_STAGES = NUM_REGS = 3 with distances 2, 1, 2; the input beat is [10, 11, 12, 13].
- Identity: all ctrl 0 → out [10, 11, 12, 13], out_val asserted exactly 3 cycles after the handshake.
- Single swap: ctrl stage0 = 2'b01, others 0 → out [12, 11, 10, 13].
- Reversal: ctrl = {2'b11, 2'b11, 2'b00} for stages 0, 1, 2 → out [13, 12, 11, 10].
- Backpressure:
  - Hold out_rdy = 0 and offer 4 beats → 3 accepted, in_rdy = 0, in_flight = 3.
  - Raise out_rdy → beats emerge in order and the 4th is accepted on the same cycle the 1st leaves.
- Streaming: 8 back-to-back beats with distinct ctrl per beat, out_rdy = 1 → 8 consecutive out_val cycles, each permuted by its own ctrl.
- Mid-flight reset: assert rst with in_flight = 2 → out_val = 0 and in_flight = 0 immediately; no stale beat appears after reset release.

Source files
------------

// File: rtl/benes_pkg.sv
// Shared sizing and routing helpers for the Benes/butterfly permutation network.
package benes_pkg;

  function automatic int stage_count(input int log_n, input bit benes);
    return benes ? (2 * log_n - 1) : log_n;
  endfunction

  function automatic int reg_count(input int stages, input int reg_every);
    return (stages + reg_every - 1) / reg_every;
  endfunction

  function automatic int cnt_width(input int regs);
    return $clog2(regs + 1);
  endfunction

  // Distances shrink to 1 across the first log2(N) stages, then a Benes network mirrors back up.
  function automatic int stage_distance(input int s, input int log_n, input bit benes);
    if (!benes || s < log_n) return 1 << (log_n - 1 - s);
    return 1 << (s - log_n + 1);
  endfunction

  function automatic int switch_lane(input int k, input int d);
    return (k / d) * 2 * d + (k % d);
  endfunction

  function automatic int slot_last_stage(input int r, input int reg_every, input int stages);
    int last;
    last = (r + 1) * reg_every - 1;
    return (last < stages) ? last : stages - 1;
  endfunction

endpackage

// File: rtl/benes_network_stage.sv
// One combinational column of 2x2 switches; each switch pairs lane a with lane a+DIST.
module benes_stage
  import benes_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 16,
  parameter int DIST       = 1
) (
  input  logic [NUM_INPUTS/2-1:0] ctrl,
  input  logic [DATA_WIDTH-1:0]   lanes_in  [NUM_INPUTS],
  output logic [DATA_WIDTH-1:0]   lanes_out [NUM_INPUTS]
);

  always_comb begin
    lanes_out = lanes_in;
    for (int k = 0; k < NUM_INPUTS / 2; k++) begin
      if (ctrl[k]) begin
        lanes_out[switch_lane(k, DIST)]        = lanes_in[switch_lane(k, DIST) + DIST];
        lanes_out[switch_lane(k, DIST) + DIST] = lanes_in[switch_lane(k, DIST)];
      end
    end
  end

endmodule

// File: rtl/benes_network.sv
// Pipelined Benes/butterfly permutation network with valid/ready backpressure.
// Switch controls ride along with their beat so every beat uses the controls it was accepted with.
module benes_network
  import benes_pkg::*;
#(
  parameter int  DATA_WIDTH   = 64,
  parameter int  NUM_INPUTS   = 16,
  parameter int  BENES        = 1,
  parameter int  REG_EVERY    = 1,
  localparam int LOG_N        = $clog2(NUM_INPUTS),
  localparam int NUM_STAGES   = stage_count(LOG_N, BENES != 0),
  localparam int NUM_SWITCHES = NUM_INPUTS / 2,
  localparam int NUM_REGS     = reg_count(NUM_STAGES, REG_EVERY),
  localparam int CNT_W        = cnt_width(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [DATA_WIDTH-1:0]   input_elements [NUM_INPUTS],
  input  logic [NUM_SWITCHES-1:0] ctrl_arr [NUM_STAGES],
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [DATA_WIDTH-1:0]   output_elements [NUM_INPUTS],
  output logic [CNT_W-1:0]        in_flight
);

  logic [NUM_REGS-1:0] v;
  logic [NUM_REGS-1:0] up_val;
  logic [NUM_REGS-1:0] load_en;
  logic [NUM_REGS:0]   ready;
  logic [DATA_WIDTH-1:0] data_q [NUM_REGS][NUM_INPUTS];
  logic [DATA_WIDTH-1:0] st_out [NUM_STAGES][NUM_INPUTS];
  logic in_hs;
  logic out_hs;

  // A slot can load when it is empty or its occupant moves on this same cycle.
  always_comb begin
    ready = '0;
    up_val = '0;
    ready[NUM_REGS] = out_rdy;
    for (int r = NUM_REGS - 1; r >= 0; r--) begin
      ready[r] = !v[r] || ready[r+1];
    end
    up_val[0] = in_val;
    for (int r = 1; r < NUM_REGS; r++) begin
      up_val[r] = v[r-1];
    end
    load_en = up_val & ready[NUM_REGS-1:0];
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int GRP = s / REG_EVERY;
    logic [DATA_WIDTH-1:0]   lanes_in [NUM_INPUTS];
    logic [NUM_SWITCHES-1:0] ctrl;

    if (s % REG_EVERY != 0) begin : g_chain
      assign lanes_in = st_out[s-1];
    end else if (GRP == 0) begin : g_input
      assign lanes_in = input_elements;
    end else begin : g_slot
      assign lanes_in = data_q[GRP-1];
    end

    if (GRP == 0) begin : g_ctrl_direct
      assign ctrl = ctrl_arr[s];
    end else begin : g_ctrl_pipe
      // Controls for this stage follow the beat through every slot in front of it.
      logic [NUM_SWITCHES-1:0] pipe [GRP];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int j = 0; j < GRP; j++) pipe[j] <= '0;
        end else begin
          if (load_en[0]) pipe[0] <= ctrl_arr[s];
          for (int j = 1; j < GRP; j++) begin
            if (load_en[j]) pipe[j] <= pipe[j-1];
          end
        end
      end
      assign ctrl = pipe[GRP-1];
    end

    benes_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_INPUTS (NUM_INPUTS),
      .DIST       (stage_distance(s, LOG_N, BENES != 0))
    ) u_stage (
      .ctrl      (ctrl),
      .lanes_in  (lanes_in),
      .lanes_out (st_out[s])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int i = 0; i < NUM_INPUTS; i++) data_q[r][i] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (ready[r]) v[r] <= up_val[r];
        if (load_en[r]) data_q[r] <= st_out[slot_last_stage(r, REG_EVERY, NUM_STAGES)];
      end
    end
  end

  assign in_hs  = in_val && ready[0];
  assign out_hs = v[NUM_REGS-1] && out_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight <= '0;
    end else if (in_hs && !out_hs) begin
      in_flight <= in_flight + 1'b1;
    end else if (out_hs && !in_hs) begin
      in_flight <= in_flight - 1'b1;
    end
  end

  assign in_rdy          = ready[0];
  assign out_val         = v[NUM_REGS-1];
  assign output_elements = data_q[NUM_REGS-1];

endmodule
